program_counter_unit: RTL and testbench

- Program counter and address-bus source mux sitting directly downstream of instruction_decode.
- Consumes the decoder's pc_enable, address_select and memory_address outputs and drives the 16-bit external address bus.
- Holds the 16-bit PC and executes increment, absolute load, two-byte vector load, and signed relative branch. A branch that crosses a page takes a one-cycle high-byte fix-up.

---
 rtl/program_counter_unit.sv | 89 ++++++++
 tb/tb_program_counter_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Program counter and address-bus source mux.
// Increment, absolute load, vector load and relative branch with page fix-up.
module program_counter_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic [2:0]  pc_enable,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  data_in,
  output logic [15:0] address_bus,
  output logic [15:0] pc_out,
  output logic        busy,
  output logic        page_cross
);

  localparam logic [2:0] CMD_LOAD_LOW  = 3'b001;
  localparam logic [2:0] CMD_LOAD_HIGH = 3'b010;
  localparam logic [2:0] CMD_INC       = 3'b011;
  localparam logic [2:0] CMD_BRANCH    = 3'b100;
  localparam logic [2:0] CMD_LOAD_ADDR = 3'b101;

  typedef enum logic {
    RUN,
    FIXUP
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [7:0]  pcl_latch;
  logic        fwd;
  logic [8:0]  sum;

  // Sign-extended offset added to the low byte; bit 8 flags a page cross
  // in either direction (carry for forward, no-borrow wrap for backward).
  assign sum = {1'b0, pc[7:0]} + {data_in[7], data_in};

  assign pc_out = pc;
  assign busy   = (state == FIXUP);

  // PC, vector latch, fix-up state and page_cross pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pcl_latch  <= 8'h00;
      state      <= RUN;
      fwd        <= 1'b0;
      page_cross <= 1'b0;
    end else if (clk_enable) begin
      page_cross <= 1'b0;
      if (state == FIXUP) begin
        pc[15:8] <= fwd ? pc[15:8] + 8'd1 : pc[15:8] - 8'd1;
        state    <= RUN;
      end else begin
        case (pc_enable)
          CMD_LOAD_LOW:  pcl_latch <= data_in;
          CMD_LOAD_HIGH: pc <= {data_in, pcl_latch};
          CMD_INC:       pc <= pc + 16'd1;
          CMD_BRANCH: begin
            pc[7:0] <= sum[7:0];
            if (sum[8]) begin
              state      <= FIXUP;
              fwd        <= ~data_in[7];
              page_cross <= 1'b1;
            end
          end
          CMD_LOAD_ADDR: pc <= memory_address;
          default: ;
        endcase
      end
    end
  end

  // Address bus source select; reset forces the PC source
  always_comb begin
    address_bus = pc;
    if (!rst) begin
      unique case (address_select)
        2'd1:    address_bus = memory_address;
        2'd2:    address_bus = {8'h00, alu_result};
        default: address_bus = pc;
      endcase
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit.
// Directed test-plan sequences followed by randomized commands.
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b0;
  logic [2:0]  pc_enable = 3'd0;
  logic [1:0]  address_select = 2'd0;
  logic [15:0] memory_address = 16'h0000;
  logic [7:0]  alu_result = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] address_bus;
  logic [15:0] pc_out;
  logic        busy;
  logic        page_cross;

  int checks = 0;
  int errors = 0;

  program_counter_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .clk_enable(clk_enable),
    .pc_enable(pc_enable),
    .address_select(address_select),
    .memory_address(memory_address),
    .alu_result(alu_result),
    .data_in(data_in),
    .address_bus(address_bus),
    .pc_out(pc_out),
    .busy(busy),
    .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] addr;
    logic        busy;
    logic        pcx;
    string       tag;
  } exp_t;

  exp_t q[$];

  // Reference model state: PC as plain integer arithmetic
  int   m_pc;
  int   m_lat;
  bit   m_fix;
  int   m_target_hi;
  bit   m_pcx;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_lat = 0;
    m_fix = 0;
    m_pcx = 0;
    m_target_hi = 0;
  endtask

  task automatic model_step(bit en, int cmd, int din, int maddr);
    int off;
    int target;
    if (!en) return;
    m_pcx = 0;
    if (m_fix) begin
      m_pc  = (m_target_hi << 8) | (m_pc & 255);
      m_fix = 0;
      return;
    end
    case (cmd)
      1: m_lat = din;
      2: m_pc = (din << 8) | m_lat;
      3: m_pc = (m_pc + 1) % 65536;
      4: begin
        off    = (din >= 128) ? din - 256 : din;
        target = (m_pc + off + 65536) % 65536;
        if ((target >> 8) != (m_pc >> 8)) begin
          m_fix       = 1;
          m_pcx       = 1;
          m_target_hi = target >> 8;
        end
        m_pc = (m_pc & 16'hFF00) | (target & 255);
      end
      5: m_pc = maddr;
      default: ;
    endcase
  endtask

  task automatic cyc(string tag, bit en, int cmd, int din,
                     int asel = 0, int maddr = 0, int alu = 0);
    exp_t e;
    clk_enable     = en;
    pc_enable      = cmd[2:0];
    data_in        = din[7:0];
    address_select = asel[1:0];
    memory_address = maddr[15:0];
    alu_result     = alu[7:0];
    model_step(en, cmd, din, maddr);
    e.pc   = m_pc[15:0];
    e.busy = m_fix;
    e.pcx  = m_pcx;
    e.tag  = tag;
    case (asel)
      1: e.addr = maddr[15:0];
      2: e.addr = {8'h00, alu[7:0]};
      default: e.addr = m_pc[15:0];
    endcase
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare DUT against the oldest expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".pc"}, pc_out, e.pc);
        chk({e.tag, ".addr"}, address_bus, e.addr);
        chk({e.tag, ".busy"}, {15'd0, busy}, {15'd0, e.busy});
        chk({e.tag, ".pcx"}, {15'd0, page_cross}, {15'd0, e.pcx});
      end
    end
  end

  initial begin
    int n;
    model_reset();
    address_select = 2'd1;
    memory_address = 16'hABCD;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.pc", pc_out, 16'h0000);
    chk("rst.addr", address_bus, 16'h0000);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.pcx", {15'd0, page_cross}, 16'd0);
    rst = 1'b0;
    address_select = 2'd0;

    repeat (3) cyc("inc", 1, 3, 0);
    cyc("ld_ffff", 1, 5, 0, 0, 16'hFFFF);
    cyc("wrap", 1, 3, 0);
    cyc("vec_lo", 1, 1, 8'h34);
    cyc("vec_hi", 1, 2, 8'h12);
    cyc("ld_1210", 1, 5, 0, 0, 16'h1210);
    cyc("br_fwd", 1, 4, 8'h05);
    cyc("ld_1210b", 1, 5, 0, 0, 16'h1210);
    cyc("br_back", 1, 4, 8'hFB);
    cyc("ld_12f0", 1, 5, 0, 0, 16'h12F0);
    cyc("xfwd", 1, 4, 8'h20);
    cyc("xfwd_fix", 1, 3, 0);
    cyc("ld_1205", 1, 5, 0, 0, 16'h1205);
    cyc("xback", 1, 4, 8'hF0);
    repeat (3) cyc("stall", 0, 3, 0);
    cyc("xback_fix", 1, 3, 0);
    cyc("mux1", 0, 0, 0, 1, 16'hABCD);
    cyc("mux2", 0, 0, 0, 2, 0, 8'h7E);
    cyc("ld_00f0", 1, 5, 0, 0, 16'h00F0);
    cyc("xpage", 1, 4, 8'h7F);

    rst = 1'b1;
    #1;
    chk("midfix.pc", pc_out, 16'h0000);
    chk("midfix.busy", {15'd0, busy}, 16'd0);
    chk("midfix.pcx", {15'd0, page_cross}, 16'd0);
    model_reset();
    #1;
    rst = 1'b0;
    cyc("post_rst", 1, 3, 0);

    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 9) < 8), $urandom_range(0, 7),
          $urandom_range(0, 255), $urandom_range(0, 3),
          $urandom_range(0, 65535), $urandom_range(0, 255));
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
